// File: rtl/fb_stream_pkg.sv
// Shared types for the framebuffer stream-out path: FSM states and output FIFO sizing.
package fb_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } fb_state_e;

  localparam int FIFO_DEPTH = 2;
  localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry {tlast,tdata} FIFO feeding the AXI-Stream master; head entry is held
// stable until popped, so the stream stays steady under backpressure.
module stream_skid_fifo
  import fb_stream_pkg::*;
#(
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W:0]       push_entry,
  input  logic             pop,
  output logic [W:0]       head,
  output logic [OCC_W-1:0] occ,
  output logic             empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [FIFO_DEPTH-1:0][W:0] mem;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;

  assign head  = mem[rd_ptr];
  assign empty = (occ == '0);

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      occ <= occ + OCC_W'(push) - OCC_W'(pop);
    end
  end

endmodule

// File: rtl/framebuffer_stream_out.sv
// Streams tile RAM words 0..count-1 out over AXI-Stream with full backpressure.
// Define FB_STREAM_CLEAR_EN to write clearColor back to each word one clk after it is read.
module framebuffer_stream_out
  import fb_stream_pkg::*;
#(
  parameter int MEM_SIZE_BYTES = 14,
  parameter int MEM_WIDTH      = 16,
  parameter int STROBE_WIDTH   = 4,
  localparam int ADDR_W        = MEM_SIZE_BYTES - $clog2(MEM_WIDTH / 8)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [ADDR_W:0]                   count,
  output logic                              busy,
  output logic                              done,
  output logic                              ramReadCs,
  output logic [ADDR_W-1:0]                 ramReadAddr,
  input  logic [MEM_WIDTH-1:0]              ramReadData,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [MEM_WIDTH-1:0]              m_axis_tdata,
`ifdef FB_STREAM_CLEAR_EN
  input  logic [MEM_WIDTH-1:0]              clearColor,
  output logic                              ramWriteCs,
  output logic                              ramWrite,
  output logic [ADDR_W-1:0]                 ramWriteAddr,
  output logic [MEM_WIDTH-1:0]              ramWriteData,
  output logic [MEM_WIDTH/STROBE_WIDTH-1:0] ramWriteMask,
`endif
  output logic                              m_axis_tlast
);

  if (MEM_WIDTH % STROBE_WIDTH != 0 || MEM_WIDTH % 8 != 0) begin : g_bad_width
    $error("MEM_WIDTH must be a multiple of 8 and of STROBE_WIDTH");
  end

  fb_state_e          state, state_nxt;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0]  last_addr;
  logic               rd_pend;
  logic               rd_pend_last;
  logic               rd_issue;
  logic               rd_is_last;
  logic               pop;
  logic               fifo_empty;
  logic [OCC_W-1:0]   occ;
  logic [OCC_W:0]     in_use;
  logic [MEM_WIDTH:0] head;

  assign pop        = m_axis_tvalid & m_axis_tready;
  assign rd_is_last = (rd_ptr == last_addr);

  // A beat leaving this cycle frees its slot, which keeps one read per clk
  // flowing while tready stays high.
  assign in_use   = (OCC_W+1)'(occ) + (OCC_W+1)'(rd_pend) - (OCC_W+1)'(pop);
  assign rd_issue = (state == FETCH) && (in_use < (OCC_W+1)'(FIFO_DEPTH));

  assign ramReadCs   = rd_issue;
  assign ramReadAddr = rd_ptr;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = head[MEM_WIDTH-1:0];
  assign m_axis_tlast  = head[MEM_WIDTH] & ~fifo_empty;

  stream_skid_fifo #(.W(MEM_WIDTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (rd_pend),
    .push_entry ({rd_pend_last, ramReadData}),
    .pop        (pop),
    .head       (head),
    .occ        (occ),
    .empty      (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (count == '0) ? DONE : FETCH;
      FETCH:   if (rd_issue && rd_is_last) state_nxt = DRAIN;
      DRAIN:   if (pop && head[MEM_WIDTH]) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      rd_ptr       <= '0;
      last_addr    <= '0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
    end else begin
      state        <= state_nxt;
      rd_pend      <= rd_issue;
      rd_pend_last <= rd_issue & rd_is_last;
      if (state == IDLE && start) begin
        rd_ptr    <= '0;
        last_addr <= ADDR_W'(count - 1'b1);
      end else if (rd_issue && !rd_is_last) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

`ifdef FB_STREAM_CLEAR_EN
  // The write trails its read by one clk, so the old word is always captured first.
  logic [ADDR_W-1:0] pend_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend_addr <= '0;
    else if (rd_issue) pend_addr <= rd_ptr;
  end

  assign ramWriteCs   = rd_pend;
  assign ramWrite     = rd_pend;
  assign ramWriteAddr = pend_addr;
  assign ramWriteData = clearColor;
  assign ramWriteMask = '1;
`endif

endmodule

// File: tb/tb_framebuffer_stream_out.sv
// Directed bench for framebuffer_stream_out with a behavioural 1-clk-latency RAM.
module tb_framebuffer_stream_out;

  localparam int AW   = 13;
  localparam int W    = 16;
  localparam int NW   = 1 << AW;
  localparam int LOGN = 16384;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   count = '0;
  logic          busy, done, ramReadCs;
  logic [AW-1:0] ramReadAddr;
  logic [W-1:0]  ramReadData;
  logic          m_axis_tvalid, m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic [W-1:0]  m_axis_tdata;
`ifdef FB_STREAM_CLEAR_EN
  logic [W-1:0]  clearColor = '0;
  logic          ramWriteCs, ramWrite;
  logic [AW-1:0] ramWriteAddr;
  logic [W-1:0]  ramWriteData;
  logic [3:0]    ramWriteMask;
`endif

  int checks = 0;
  int errors = 0;

  framebuffer_stream_out dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .count         (count),
    .busy          (busy),
    .done          (done),
    .ramReadCs     (ramReadCs),
    .ramReadAddr   (ramReadAddr),
    .ramReadData   (ramReadData),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
`ifdef FB_STREAM_CLEAR_EN
    .clearColor    (clearColor),
    .ramWriteCs    (ramWriteCs),
    .ramWrite      (ramWrite),
    .ramWriteAddr  (ramWriteAddr),
    .ramWriteData  (ramWriteData),
    .ramWriteMask  (ramWriteMask),
`endif
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 clk = ~clk;

  // RAM model: RAM[i] = A000+i after an init pulse.
  logic [W-1:0] ram [NW];
  logic         ram_init = 1'b0;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < NW; i++) ram[i] <= W'(32'hA000 + i);
    end else begin
`ifdef FB_STREAM_CLEAR_EN
      if (ramWriteCs && ramWrite && ramWriteMask == 4'hF) ram[ramWriteAddr] <= ramWriteData;
`endif
    end
    if (ramReadCs) ramReadData <= ram[ramReadAddr];
  end

  // Monitor: beat log, outstanding-read high-water mark, stall stability.
  int           beat_total = 0, rd_total = 0, pop_total = 0;
  int           max_out = 0, stall_err = 0, tv_cycles = 0, rd_cycles = 0;
  logic [W:0]   beat_log [LOGN];
  logic         prev_stall = 1'b0;
  logic [W:0]   prev_beat = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_total   <= pop_total;
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata} != prev_beat))
        stall_err <= stall_err + 1;
      prev_stall <= m_axis_tvalid && !m_axis_tready;
      prev_beat  <= {m_axis_tlast, m_axis_tdata};
      if (m_axis_tvalid) tv_cycles <= tv_cycles + 1;
      if (ramReadCs) begin
        rd_total  <= rd_total + 1;
        rd_cycles <= rd_cycles + 1;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        beat_log[beat_total % LOGN] <= {m_axis_tlast, m_axis_tdata};
        beat_total <= beat_total + 1;
        pop_total  <= pop_total + 1;
      end
      if (rd_total - pop_total > max_out) max_out <= rd_total - pop_total;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic init_ram();
    @(negedge clk) ram_init = 1'b1;
    @(negedge clk) ram_init = 1'b0;
  endtask

  function automatic logic pat(input int mode, input int k);
    logic [3:0] p;
    p = 4'b1001;  // bit k%4: 1,0,0,1
    return (mode == 0) ? 1'b1 : p[k % 4];
  endfunction

  // Pulse start at a negedge; negedge k samples state after the k-th edge.
  task automatic run(input int c, input int budget, input int mode,
                     output int done_k, output int first_v);
    done_k  = -1;
    first_v = -1;
    @(negedge clk);
    start = 1'b1;
    count = (AW+1)'(c);
    m_axis_tready = pat(mode, 0);
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (m_axis_tvalid && first_v < 0) first_v = k;
      if (done) begin
        done_k = k;
        break;
      end
      m_axis_tready = pat(mode, k);
    end
    m_axis_tready = 1'b1;
  endtask

  task automatic chk_beats(input string tag, input int base, input int n);
    int bad = 0;
    logic [W:0] e;
    for (int j = 0; j < n; j++) begin
      e = {(j == n - 1), W'(32'hA000 + j)};
      if (beat_log[(base + j) % LOGN] !== e) bad++;
    end
    chk({tag, " beats"}, beat_total - base, n);
    chk({tag, " data/last bad"}, bad, 0);
  endtask

  initial begin
    int dk, fv, base, sb, tvb, rdb;
    #3;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst rdcs", ramReadCs, 0);
    chk("rst tvalid", m_axis_tvalid, 0);
    chk("rst tlast", m_axis_tlast, 0);
    chk("rst tdata", m_axis_tdata, 0);
    chk("rst addr", ramReadAddr, 0);
`ifdef FB_STREAM_CLEAR_EN
    chk("rst wcs", {ramWriteCs, ramWrite}, 0);
`endif
    @(negedge clk) reset = 1'b1;
    init_ram();

    // count=4, tready=1
    base = beat_total;
    run(4, 30, 0, dk, fv);
    chk("c4 first tvalid", fv, 3);
    chk("c4 done cycle", dk, 7);
    chk_beats("c4", base, 4);
    @(negedge clk);
    chk("c4 done pulse width", done, 0);
    chk("c4 busy after", busy, 0);

    // count=8 with tready 1,0,0,1
    init_ram();
    base = beat_total;
    sb   = stall_err;
    run(8, 80, 1, dk, fv);
    chk("c8 done seen", dk > 0, 1);
    chk_beats("c8", base, 8);
    chk("c8 stall stable", stall_err - sb, 0);
    chk("c8 outstanding<=2", max_out <= 2, 1);

    // count=0
    tvb = tv_cycles;
    rdb = rd_cycles;
    run(0, 10, 0, dk, fv);
    chk("c0 done cycle", dk, 1);
    @(negedge clk);
    chk("c0 no reads", rd_cycles - rdb, 0);
    chk("c0 no tvalid", tv_cycles - tvb, 0);

    // count=2^AW: whole RAM
    init_ram();
    base = beat_total;
    run(NW, NW + 20, 0, dk, fv);
    chk("full done cycle", dk, NW + 3);
    chk_beats("full", base, NW);
    chk("full addr no wrap", ramReadAddr, NW - 1);

    // reset after 3 beats of count=16
    init_ram();
    base = beat_total;
    @(negedge clk);
    start = 1'b1;
    count = 16;
    dk = 0;
    for (int k = 0; k < 40 && (beat_total - base) < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) dk = 1;
    end
    chk("rst16 3 beats", beat_total - base, 3);
    chk("rst16 no early done", dk, 0);
    #1 reset = 1'b0;
    #1;
    chk("rst16 busy", busy, 0);
    chk("rst16 tvalid", m_axis_tvalid, 0);
    chk("rst16 rdcs", ramReadCs, 0);
    chk("rst16 tdata", m_axis_tdata, 0);
    chk("rst16 addr", ramReadAddr, 0);
    @(negedge clk);
    chk("rst16 done held", done, 0);
    reset = 1'b1;
    base = beat_total;
    run(4, 30, 0, dk, fv);
    chk("post-rst done cycle", dk, 7);
    chk_beats("post-rst", base, 4);

`ifdef FB_STREAM_CLEAR_EN
    init_ram();
    clearColor = 16'h1234;
    base = beat_total;
    run(4, 30, 0, dk, fv);
    chk_beats("clr", base, 4);
    @(negedge clk);
    @(negedge clk);
    chk("clr ram0", ram[0], 16'h1234);
    chk("clr ram1", ram[1], 16'h1234);
    chk("clr ram2", ram[2], 16'h1234);
    chk("clr ram3", ram[3], 16'h1234);
    chk("clr ram4", ram[4], 16'hA004);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
